// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single physical-memory line port between I-cache and D-cache.
// One transaction in flight; round-robin on contention; command/address/data latched at grant.
module cache_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    typedef enum logic [1:0] {IDLE = 2'd0, I_BUSY = 2'd1, D_BUSY = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic              d_req, grant_d, grant_i;

    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        d_req        = d_read | d_write;
        // On contention the side that did not win last time is granted.
        grant_d      = (state_q == IDLE) && d_req && (!i_read || !last_d_q);
        grant_i      = (state_q == IDLE) && i_read && !grant_d;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = D_BUSY;
                    last_d_d     = 1'b1;
                    pmem_write_d = d_write;
                    pmem_read_d  = !d_write;
                    pmem_addr_d  = d_addr;
                    pmem_wdata_d = d_wdata;
                end else if (grant_i) begin
                    state_d      = I_BUSY;
                    last_d_d     = 1'b0;
                    pmem_read_d  = 1'b1;
                    pmem_write_d = 1'b0;
                    pmem_addr_d  = i_addr;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_d_q     <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_d_q     <= last_d_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
        end
    end

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;
    // Completion is combinational off pmem_resp and only to the granted side.
    assign i_resp     = (state_q == I_BUSY) && pmem_resp;
    assign d_resp     = (state_q == D_BUSY) && pmem_resp;
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_cache_mem_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, pmem_resp;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, pmem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_addr;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Transaction-level model: who owns the memory port and what was latched for it.
    int            m_owner;   // 0 none, 1 I-cache, 2 D-cache
    bit            m_last_d;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            i_done, d_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_last_d = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
            i_done = 0; d_done = 0;
        end else begin
            i_done = 0; d_done = 0;
            if (m_owner != 0) begin
                if (pmem_resp) begin
                    i_done  = (m_owner == 1);
                    d_done  = (m_owner == 2);
                    m_owner = 0;
                end
            end else begin
                bit wi, wd;
                wi = i_read;
                wd = d_read | d_write;
                if (wi && wd) m_owner = m_last_d ? 1 : 2;
                else if (wd)  m_owner = 2;
                else if (wi)  m_owner = 1;
                if (m_owner == 2) begin
                    m_last_d = 1; m_wr = d_write; m_addr = d_addr; m_wdata = d_wdata;
                end else if (m_owner == 1) begin
                    m_last_d = 0; m_wr = 0; m_addr = i_addr;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        chk("pmem_read",  pmem_read,  (m_owner != 0) && !m_wr);
        chk("pmem_write", pmem_write, (m_owner != 0) && m_wr);
        chk("pmem_addr",  pmem_addr,  m_addr);
        chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("i_resp",     i_resp,     (m_owner == 1) && pmem_resp);
        chk("d_resp",     d_resp,     (m_owner == 2) && pmem_resp);
        if (i_resp) chk("i_rdata", i_rdata, pmem_rdata);
        if (d_resp) chk("d_rdata", d_rdata, pmem_rdata);
    end

    task automatic idle_inputs();
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; idle_inputs();
        @(negedge clk); rst = 0;
    endtask

    logic [LW-1:0] line_a, line_b;

    initial begin
        line_a = {8{32'hA5A5_0001}};
        line_b = {8{32'h5A5A_0002}};
        rst = 1; idle_inputs();
        i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_read", pmem_read, 0);
        chk("rst_write", pmem_write, 0);
        chk("rst_addr", pmem_addr, 0);
        chk("rst_wdata", pmem_wdata, 0);
        @(negedge clk); rst = 0;

        // Lone I-cache read.
        @(negedge clk); i_read = 1; i_addr = 32'h60;
        @(negedge clk); pmem_resp = 1; pmem_rdata = line_a;
        #2; chk("t1_read", pmem_read, 1); chk("t1_addr", pmem_addr, 32'h60);
        chk("t1_resp", i_resp, 1); chk("t1_rdata", i_rdata, line_a); chk("t1_dresp", d_resp, 0);
        @(negedge clk); i_read = 0; pmem_resp = 0;
        #2; chk("t1_clear", pmem_read, 0); chk("t1_resp_off", i_resp, 0);

        // Lone D-cache write-back, held for two cycles before completion.
        @(negedge clk); d_write = 1; d_addr = 32'h80; d_wdata = line_b;
        @(negedge clk); d_wdata = '0;
        #2; chk("t2_write", pmem_write, 1); chk("t2_wdata", pmem_wdata, line_b);
        chk("t2_addr", pmem_addr, 32'h80); chk("t2_read", pmem_read, 0);
        @(negedge clk); pmem_resp = 1;
        #2; chk("t2_hold", pmem_wdata, line_b); chk("t2_resp", d_resp, 1);
        @(negedge clk); pmem_resp = 0; d_write = 0;
        #2; chk("t2_clear", pmem_write, 0); chk("t2_resp_off", d_resp, 0);

        // Contention after reset: D first, then strict alternation.
        do_reset();
        @(negedge clk); i_read = 1; d_read = 1; i_addr = 32'h200; d_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); pmem_resp = 1;
            #2; chk("t3_addr", pmem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("t3_read", pmem_read, 1);
            chk("t3_iresp", i_resp, (k % 2 == 1));
            chk("t3_dresp", d_resp, (k % 2 == 0));
            @(negedge clk); pmem_resp = 0;
            if (k == 3) begin i_read = 0; d_read = 0; end
            #2; chk("t3_gap", pmem_read, 0);
        end

        // Inputs ignored while busy; D waits for I to finish plus a gap.
        @(negedge clk); i_read = 1; i_addr = 32'h40;
        @(negedge clk); i_addr = 32'hFF; d_read = 1; d_addr = 32'h300;
        #2; chk("t4_addr", pmem_addr, 32'h40);
        @(negedge clk); pmem_resp = 1;
        #2; chk("t4_addr2", pmem_addr, 32'h40); chk("t4_iresp", i_resp, 1); chk("t4_dresp", d_resp, 0);
        @(negedge clk); pmem_resp = 0; i_read = 0;
        #2; chk("t4_gap", pmem_read, 0);
        @(negedge clk); pmem_resp = 1;
        #2; chk("t4_daddr", pmem_addr, 32'h300); chk("t4_dresp2", d_resp, 1);
        @(negedge clk); pmem_resp = 0; d_read = 0;

        // Reset in the middle of a D write.
        @(negedge clk); d_write = 1; d_addr = 32'h500;
        @(negedge clk);
        #2; chk("t5_write", pmem_write, 1);
        pmem_resp = 1;
        #1; rst = 1;
        #1; chk("t5_drop", pmem_write, 0); chk("t5_noresp", d_resp, 0); chk("t5_addr", pmem_addr, 0);
        @(negedge clk); rst = 0; d_write = 0; pmem_resp = 0;

        // Stray memory response while idle.
        @(negedge clk); pmem_resp = 1;
        #2; chk("t6_iresp", i_resp, 0); chk("t6_dresp", d_resp, 0);
        @(negedge clk); pmem_resp = 0;
        #2; chk("t6_read", pmem_read, 0); chk("t6_write", pmem_write, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rst) rst = 0;
            else if ($urandom % 250 == 0) rst = 1;
            if (i_read) begin
                if (i_done) i_read = ($urandom % 4 == 0);
                else if ($urandom % 20 == 0) i_read = 0;
            end else begin
                i_read = ($urandom % 3 == 0);
            end
            if (d_read || d_write) begin
                if ((d_done && $urandom % 4 != 0) || $urandom % 20 == 0) begin
                    d_read = 0; d_write = 0;
                end
            end else begin
                int kd;
                kd = $urandom % 4;
                d_read  = (kd == 0) || (kd == 2);
                d_write = (kd == 1) || (kd == 2);
            end
            if ($urandom % 3 == 0) i_addr = $urandom;
            if ($urandom % 3 == 0) d_addr = $urandom;
            if ($urandom % 3 == 0) d_wdata = rand_line();
            pmem_resp  = ($urandom % 3 == 0);
            pmem_rdata = rand_line();
        end
        @(negedge clk); rst = 0; idle_inputs();
        repeat (3) @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
